// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with TX FIFO, runtime baud divisor and 1/2 stop bits
//
// Optional feature macro: UART_TX_PARITY_EN (adds even/odd parity bit selected by cfg_parity).
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   baud_div     bit period in clk cycles minus 1 (sampled at frame start)
//   cfg_stop2    0: one stop bit, 1: two stop bits (sampled at frame start)
//   cfg_parity   00/11 none, 01 even, 10 odd (only with UART_TX_PARITY_EN)
//   in_valid     write request; a word is queued when in_valid && in_ready
//   in_ready     FIFO has a free slot
//   in_data      character to queue
//   serial_out   TX line, idles high
//   busy         frame in progress or FIFO non-empty
//   fifo_level   number of queued words
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic                        cfg_stop2,
    input  logic [1:0]                  cfg_parity,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_BITS-1:0]        in_data,
    output logic                        serial_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    // Shift register holds everything after the start bit: data, parity slot, stop bits.
    localparam int SR_W  = DATA_BITS + 3;
    localparam int CNT_W = $clog2(DATA_BITS + 5);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 start;
    logic                 active;
    logic                 bit_edge;
    logic                 last_bit;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     frame_len;
    logic [DIV_W-1:0]     cyc;
    logic [DIV_W-1:0]     div_q;
    logic [SR_W-1:0]      sr;
    logic [SR_W-1:0]      sr_load;
    logic                 par_en;

`ifdef UART_TX_PARITY_EN
    logic par_bit;
    assign par_en  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    // cfg_parity[1] is set only for odd mode, which inverts the XOR.
    assign par_bit = (^head) ^ cfg_parity[1];
    assign sr_load = par_en ? {2'b11, par_bit, head} : {3'b111, head};
`else
    logic unused_parity;
    assign unused_parity = ^cfg_parity;
    assign par_en        = 1'b0;
    assign sr_load       = {3'b111, head};
`endif

    assign head     = mem[rd_ptr];
    assign in_ready = (fifo_level != LW'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign active   = (bit_cnt != '0);
    assign busy     = active || (fifo_level != '0);
    assign bit_edge = active && (cyc == div_q);
    assign last_bit = bit_edge && (bit_cnt == CNT_W'(1));
    // A new frame starts when idle, or on the very edge the last stop bit ends.
    assign start    = (fifo_level != '0) && (!active || last_bit);

    always_comb begin
        frame_len = CNT_W'(DATA_BITS + 2);
        if (cfg_stop2) begin
            frame_len = frame_len + CNT_W'(1);
        end
        if (par_en) begin
            frame_len = frame_len + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (start) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, start})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            serial_out <= 1'b1;
            bit_cnt    <= '0;
            cyc        <= '0;
            div_q      <= '0;
            sr         <= '1;
        end else if (start) begin
            serial_out <= 1'b0;
            sr         <= sr_load;
            bit_cnt    <= frame_len;
            cyc        <= '0;
            div_q      <= baud_div;
        end else if (bit_edge) begin
            cyc     <= '0;
            bit_cnt <= bit_cnt - CNT_W'(1);
            if (last_bit) begin
                serial_out <= 1'b1;
            end else begin
                serial_out <= sr[0];
                sr         <= {1'b1, sr[SR_W-1:1]};
            end
        end else if (active) begin
            cyc <= cyc + DIV_W'(1);
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo against a frame-level line model
module tb_uart_tx_fifo;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] baud_div;
    logic          cfg_stop2;
    logic [1:0]    cfg_parity;
    logic          in_valid;
    logic          in_ready;
    logic [DB-1:0] in_data;
    logic          serial_out;
    logic          busy;
    logic [2:0]    fifo_level;

    uart_tx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
        .clk(clk), .rst(rst), .baud_div(baud_div), .cfg_stop2(cfg_stop2),
        .cfg_parity(cfg_parity), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .serial_out(serial_out), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;
    int peak     = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of pending words plus the line level for each remaining cycle of the frame.
    int q[$];
    bit wave[$];
    bit m_acc;

    function automatic void build_frame(input int d);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(bit'((d >> i) & 1));
`ifdef UART_TX_PARITY_EN
        if (cfg_parity == 2'b01) bits.push_back(bit'($countones(d) % 2));
        if (cfg_parity == 2'b10) bits.push_back(bit'(1 - $countones(d) % 2));
`endif
        bits.push_back(1'b1);
        if (cfg_stop2) bits.push_back(1'b1);
        foreach (bits[i])
            for (int c = 0; c <= int'(baud_div); c++) wave.push_back(bits[i]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            wave.delete();
        end else begin
            m_acc = in_valid && (q.size() != DEPTH);
            if (wave.size() != 0) void'(wave.pop_front());
            if (wave.size() == 0 && q.size() != 0) build_frame(q.pop_front());
            if (m_acc) q.push_back(int'(in_data));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("serial_out", int'(serial_out), (wave.size() != 0) ? int'(wave[0]) : 1);
            check("busy", int'(busy), int'(wave.size() != 0 || q.size() != 0));
            check("fifo_level", int'(fifo_level), q.size());
            check("in_ready", int'(in_ready), int'(q.size() != DEPTH));
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
    end

    int tx[$];
    bit rec[$];

    task automatic send_all();
        foreach (tx[i]) begin
            int guard;
            guard    = 0;
            in_valid = 1'b1;
            in_data  = DB'(tx[i]);
            while (!in_ready && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) check("push_timeout", 0, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic record(input int limit);
        int k;
        k = 0;
        rec.delete();
        while (!busy && k < limit) begin
            @(negedge clk);
            k++;
        end
        while (busy && k < limit) begin
            rec.push_back(serial_out);
            @(negedge clk);
            k++;
        end
        check("record_done", int'(k < limit), 1);
    endtask

    task automatic send_rec(input int limit);
        fork
            send_all();
            record(limit);
        join
    endtask

    function automatic int ones_tail(input int n);
        int s;
        s = 0;
        for (int i = rec.size() - n; i < rec.size(); i++) s += int'(rec[i]);
        return s;
    endfunction

    logic [9:0]  v10;
    logic [20:0] v21;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        baud_div = 16'd3; cfg_stop2 = 1'b0; cfg_parity = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_serial", int'(serial_out), 1);
        check("rst_level", int'(fifo_level), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(in_ready), 1);
        rst = 1'b0;
        chk_en = 1'b1;

        // 0xA5, 4 cycles per bit, one stop bit
        tx = '{32'hA5};
        send_rec(300);
        check("a5_len", rec.size(), 41);
        for (int i = 0; i < 10; i++) v10[i] = rec[1 + 4 * i];
        check("a5_bits", int'(v10), int'(10'b1101001010));
        check("a5_idle", int'(serial_out), 1);

        // even parity
        cfg_parity = 2'b01;
        send_rec(300);
        check("even_len", rec.size(), 1 + 4 * (10 + PB));
        check("even_bit9", int'(rec[37]), (PB == 1) ? 0 : 1);

        // odd parity
        cfg_parity = 2'b10;
        send_rec(300);
        check("odd_len", rec.size(), 1 + 4 * (10 + PB));
        check("odd_bit9", int'(rec[37]), 1);

        // odd parity + two stop bits
        cfg_stop2 = 1'b1;
        send_rec(300);
        check("stop2_len", rec.size(), 1 + 4 * (11 + PB));
        check("stop2_tail", ones_tail(8), 8);
        cfg_stop2 = 1'b0; cfg_parity = 2'b00;

        // burst into a 4-deep FIFO, 2 cycles per bit, back-to-back frames
        baud_div = 16'd1;
        peak = 0;
        tx = '{1, 2, 3, 4, 5, 6, 7, 8};
        send_rec(1000);
        check("burst_len", rec.size(), 161);
        check("burst_peak", peak, 4);

        // 0xFF, 0x00 at one cycle per bit
        baud_div = 16'd0;
        tx = '{32'hFF, 32'h00};
        send_rec(300);
        check("fast_len", rec.size(), 21);
        for (int i = 0; i < 21; i++) v21[i] = rec[i];
        check("fast_bits", int'(v21), int'(21'b100000000011111111101));

        // divisor changed mid-frame applies to the next frame only
        baud_div = 16'd3;
        tx = '{32'h55, 32'h0F};
        fork
            send_all();
            record(500);
            begin
                repeat (12) @(negedge clk);
                baud_div = 16'd7;
            end
        join
        check("div_change_len", rec.size(), 121);
        check("div_change_f1_bit2", int'(rec[1 + 4 * 2]), 0);
        baud_div = 16'd3;

        // reset during data bit 3 with two words queued
        tx = '{32'h11, 32'h22, 32'h33};
        send_all();
        repeat (16) @(negedge clk);
        check("pre_rst_level", int'(fifo_level), 2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_serial", int'(serial_out), 1);
        check("midrst_level", int'(fifo_level), 0);
        check("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        tx = '{32'h3C};
        send_rec(300);
        check("post_rst_len", rec.size(), 41);
        for (int i = 0; i < 10; i++) v10[i] = rec[1 + 4 * i];
        check("post_rst_bits", int'(v10), int'(10'b1001111000));

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
